range_sample_framer: RTL and testbench

- Upstream feeder for the range-finder stage.
- Accepts a valid/ready stream of WIDTH-bit samples, each burst delimited by in_last, and buffers them in a small FIFO.
- Converts each burst into the range-finder framing: rf_go on the first sample, one sample per cycle after that, then a single rf_finish cycle.
- Also flags the one cycle in which the range-finder's range output is valid for the burst just closed.

---
 rtl/range_sample_framer_pkg.sv | 24 ++
 rtl/range_sample_framer_fifo.sv | 64 ++++++
 rtl/range_sample_framer.sv | 129 ++++++++++++
 tb/tb_range_sample_framer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/range_sample_framer_pkg.sv
// Shared types and constants for the range-finder sample framer.
package range_pkg;

  localparam int unsigned RANGE_WIDTH = 10;
  localparam int unsigned BURST_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST,
    DONE
  } framer_state_t;

  typedef struct packed {
    logic                   last;
    logic [RANGE_WIDTH-1:0] data;
  } sample_t;

  // Burst sample counter increment that sticks at all-ones.
  function automatic logic [BURST_CNT_W-1:0] sat_inc(input logic [BURST_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/range_sample_framer_fifo.sv
// Small synchronous FIFO with wrap-around pointers; DEPTH must be a power of two.
module sample_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/range_sample_framer.sv
// Buffers a valid/ready sample stream and reframes each burst as
// rf_go / samples / rf_finish, then flags the range-result cycle.
module range_sample_framer
  import range_pkg::*;
#(
  parameter int unsigned WIDTH = RANGE_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       rf_data,
  output logic                   rf_go,
  output logic                   rf_finish,
  output logic                   result_valid,
  output logic                   busy,
  output logic [BURST_CNT_W-1:0] burst_len
);

  logic [WIDTH:0]         fifo_dout;
  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   head_last;
  logic [WIDTH-1:0]       head_data;
  logic                   start;

  framer_state_t          state_q, state_d;
  logic [WIDTH-1:0]       rf_data_q, rf_data_d;
  logic                   go_q, go_d;
  logic                   fin_q, fin_d;
  logic                   rv_q, rv_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic [BURST_CNT_W-1:0] len_q, len_d;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign head_last = fifo_dout[WIDTH];
  assign head_data = fifo_dout[WIDTH-1:0];

  sample_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .din_i   ({in_last, in_data}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state and registered-output logic for the framing FSM.
  always_comb begin
    state_d   = state_q;
    rf_data_d = rf_data_q;
    go_d      = 1'b0;
    fin_d     = 1'b0;
    rv_d      = 1'b0;
    cnt_d     = cnt_q;
    len_d     = len_q;
    fifo_pop  = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: start = !fifo_empty;
      RUN: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rf_data_d = head_data;
          cnt_d     = sat_inc(cnt_q);
          if (head_last) state_d = LAST;
        end
      end
      LAST: begin
        fin_d   = 1'b1;
        len_d   = cnt_q;
        state_d = DONE;
      end
      DONE: begin
        rv_d    = 1'b1;
        state_d = IDLE;
        start   = !fifo_empty;
      end
      default: state_d = IDLE;
    endcase
    // Burst start shared by IDLE and DONE so back-to-back bursts lose no cycle.
    if (start) begin
      fifo_pop  = 1'b1;
      rf_data_d = head_data;
      go_d      = 1'b1;
      cnt_d     = BURST_CNT_W'(1);
      state_d   = head_last ? LAST : RUN;
    end
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rf_data_q <= '0;
      go_q      <= 1'b0;
      fin_q     <= 1'b0;
      rv_q      <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      rf_data_q <= rf_data_d;
      go_q      <= go_d;
      fin_q     <= fin_d;
      rv_q      <= rv_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
    end
  end

  assign rf_data      = rf_data_q;
  assign rf_go        = go_q;
  assign rf_finish    = fin_q;
  assign result_valid = rv_q;
  assign burst_len    = len_q;
  assign busy         = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_range_sample_framer.sv
// Directed table-driven bench for range_sample_framer.
module tb_range_sample_framer;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  in_data;
  logic        in_last, in_valid, in_ready;
  logic [9:0]  rf_data;
  logic        rf_go, rf_finish, result_valid, busy;
  logic [15:0] burst_len;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int rst, v, d, l;
    int rdy, go, fin, rv, data, busy, len;
  } vec_t;

  vec_t rows[$];

  range_sample_framer #(.WIDTH(10), .DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rf_data      (rf_data),
    .rf_go        (rf_go),
    .rf_finish    (rf_finish),
    .result_valid (result_valid),
    .busy         (busy),
    .burst_len    (burst_len)
  );

  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int rst, input int v, input int d, input int l,
                              input int rdy, input int go, input int fin, input int rv,
                              input int data, input int bsy, input int len);
    vec_t r;
    r = '{rst, v, d, l, rdy, go, fin, rv, data, bsy, len};
    rows.push_back(r);
  endfunction

  // Drive each row's inputs at the falling edge and check the outputs of that cycle.
  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      reset    = (rows[i].rst != 0);
      in_valid = (rows[i].v != 0);
      in_data  = 10'(rows[i].d);
      in_last  = (rows[i].l != 0);
      chk($sformatf("row%0d in_ready", i),     int'(in_ready),     rows[i].rdy);
      chk($sformatf("row%0d rf_go", i),        int'(rf_go),        rows[i].go);
      chk($sformatf("row%0d rf_finish", i),    int'(rf_finish),    rows[i].fin);
      chk($sformatf("row%0d result_valid", i), int'(result_valid), rows[i].rv);
      chk($sformatf("row%0d rf_data", i),      int'(rf_data),      rows[i].data);
      chk($sformatf("row%0d busy", i),         int'(busy),         rows[i].busy);
      chk($sformatf("row%0d burst_len", i),    int'(burst_len),    rows[i].len);
      @(negedge clock);
    end
  endtask

  initial begin
    int seg_a_end, seg_b_end, cyc, pushed, fin_seen;
    bit accepted;
    int got[$];
    int exp_drain[4];

    exp_drain = '{22, 23, 24, 25};

    //   rst v  d   l   rdy go fin rv data busy len
    // Burst 5,9,2,7 straight after reset.
    add(0, 1, 5,   0,  1, 0, 0, 0, 0,   0, 0);
    add(0, 1, 9,   0,  1, 0, 0, 0, 0,   1, 0);
    add(0, 1, 2,   0,  1, 1, 0, 0, 5,   1, 0);
    add(0, 1, 7,   1,  1, 0, 0, 0, 9,   1, 0);
    add(0, 0, 0,   0,  1, 0, 0, 0, 2,   1, 0);
    add(0, 0, 0,   0,  1, 0, 0, 0, 7,   1, 0);
    add(0, 0, 0,   0,  1, 0, 1, 0, 7,   1, 4);
    add(0, 0, 0,   0,  1, 0, 0, 1, 7,   0, 4);
    // Single-sample burst 300.
    add(0, 1, 300, 1,  1, 0, 0, 0, 7,   0, 4);
    add(0, 0, 0,   0,  1, 0, 0, 0, 7,   1, 4);
    add(0, 0, 0,   0,  1, 1, 0, 0, 300, 1, 4);
    add(0, 0, 0,   0,  1, 0, 1, 0, 300, 1, 1);
    add(0, 0, 0,   0,  1, 0, 0, 1, 300, 0, 1);
    // Gapped burst 3, three idle cycles, 8 last.
    add(0, 1, 3,   0,  1, 0, 0, 0, 300, 0, 1);
    add(0, 0, 0,   0,  1, 0, 0, 0, 300, 1, 1);
    add(0, 0, 0,   0,  1, 1, 0, 0, 3,   1, 1);
    add(0, 0, 0,   0,  1, 0, 0, 0, 3,   1, 1);
    add(0, 1, 8,   1,  1, 0, 0, 0, 3,   1, 1);
    add(0, 0, 0,   0,  1, 0, 0, 0, 3,   1, 1);
    add(0, 0, 0,   0,  1, 0, 0, 0, 8,   1, 1);
    add(0, 0, 0,   0,  1, 0, 1, 0, 8,   1, 2);
    add(0, 0, 0,   0,  1, 0, 0, 1, 8,   0, 2);
    // Back-to-back {1,4L}{6,6L} then single-sample bursts until the FIFO fills.
    add(0, 1, 1,   0,  1, 0, 0, 0, 8,   0, 2);
    add(0, 1, 4,   1,  1, 0, 0, 0, 8,   1, 2);
    add(0, 1, 6,   0,  1, 1, 0, 0, 1,   1, 2);
    add(0, 1, 6,   1,  1, 0, 0, 0, 4,   1, 2);
    add(0, 1, 20,  1,  1, 0, 1, 0, 4,   1, 2);
    add(0, 1, 21,  1,  1, 1, 0, 1, 6,   1, 2);
    add(0, 1, 22,  1,  1, 0, 0, 0, 6,   1, 2);
    add(0, 1, 23,  1,  1, 0, 1, 0, 6,   1, 2);
    add(0, 1, 24,  1,  1, 1, 0, 1, 20,  1, 2);
    add(0, 1, 25,  1,  0, 0, 1, 0, 20,  1, 1);
    add(0, 1, 25,  1,  1, 1, 0, 1, 21,  1, 1);
    add(0, 1, 26,  1,  0, 0, 1, 0, 21,  1, 1);
    seg_a_end = rows.size() - 1;
    // Reset in RUN after two samples, then a fresh burst 50,51L.
    add(0, 1, 40,  0,  1, 0, 0, 0, 25,  0, 1);
    add(0, 1, 41,  0,  1, 0, 0, 0, 25,  1, 1);
    add(0, 0, 0,   0,  1, 1, 0, 0, 40,  1, 1);
    add(1, 0, 0,   0,  1, 0, 0, 0, 41,  1, 1);
    add(0, 0, 0,   0,  1, 0, 0, 0, 0,   0, 0);
    add(0, 0, 0,   0,  1, 0, 0, 0, 0,   0, 0);
    add(0, 1, 50,  0,  1, 0, 0, 0, 0,   0, 0);
    add(0, 1, 51,  1,  1, 0, 0, 0, 0,   1, 0);
    add(0, 0, 0,   0,  1, 1, 0, 0, 50,  1, 0);
    add(0, 0, 0,   0,  1, 0, 0, 0, 51,  1, 0);
    add(0, 0, 0,   0,  1, 0, 1, 0, 51,  1, 2);
    add(0, 0, 0,   0,  1, 0, 0, 1, 51,  0, 2);
    add(0, 0, 0,   0,  1, 0, 0, 0, 51,  0, 2);
    seg_b_end = rows.size() - 1;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(negedge clock);

    run_rows(0, seg_a_end);

    // Drain: the refused sample 26 must never appear.
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 60) begin
      if (rf_go) got.push_back(int'(rf_data));
      @(negedge clock);
      cyc++;
    end
    chk("drain_idle", int'(busy), 0);
    chk("drain_go_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_go_data%0d", i), (i < got.size()) ? got[i] : -1, exp_drain[i]);
    end
    @(negedge clock);

    run_rows(seg_a_end + 1, seg_b_end);

    // 70000-sample burst: length saturates, finish still arrives.
    pushed   = 0;
    fin_seen = 0;
    cyc      = 0;
    while (pushed < 70000 && cyc < 80000) begin
      in_valid = 1'b1;
      in_data  = pushed[9:0];
      in_last  = (pushed == 69999);
      if (rf_finish) fin_seen++;
      accepted = in_ready;
      @(negedge clock);
      if (accepted) pushed++;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("long_pushed", pushed, 70000);
    cyc = 0;
    while (!rf_finish && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("long_early_finish", fin_seen, 0);
    chk("long_finish", int'(rf_finish), 1);
    chk("long_finish_data", int'(rf_data), 367);
    chk("long_burst_len", int'(burst_len), 65535);
    @(negedge clock);
    chk("long_result_valid", int'(result_valid), 1);
    chk("long_len_held", int'(burst_len), 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
